// File: rtl/mem_arb_pkg.sv
// Shared types and owner encodings for the two-cache memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the I-cache and D-cache requests.
// MEM_ARB_RR_EN selects round-robin tie-breaking; otherwise the D-cache wins ties.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last_winner,
  output logic grant_valid,
  output logic grant_owner
);

  logic w_tie_owner;

`ifdef MEM_ARB_RR_EN
  // On a tie the requester that did not win last time goes next.
  assign w_tie_owner = (last_winner == OWN_D) ? OWN_I : OWN_D;
`else
  logic w_unused_last_winner;
  assign w_unused_last_winner = last_winner;
  assign w_tie_owner          = OWN_D;
`endif

  // Winner select: a lone request wins outright, a tie goes to w_tie_owner.
  always_comb begin
    grant_valid = i_req | d_req;
    if (i_req && d_req) begin
      grant_owner = w_tie_owner;
    end else if (d_req) begin
      grant_owner = OWN_D;
    end else begin
      grant_owner = OWN_I;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the I-cache and D-cache; grants one at a time.
// Tie policy is set by MEM_ARB_RR_EN inside mem_arb_pick.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_t        r_state;
  logic              r_last_winner;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic w_i_req;
  logic w_d_req;
  logic w_grant_valid;
  logic w_grant_owner;

  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;

  mem_arb_pick u_pick (
    .i_req       (w_i_req),
    .d_req       (w_d_req),
    .last_winner (r_last_winner),
    .grant_valid (w_grant_valid),
    .grant_owner (w_grant_owner)
  );

  // Grant FSM; the memory request is latched at grant and held until mem_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_last_winner <= OWN_D;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_addr    <= {ADDR_W{1'b0}};
      r_mem_wdata   <= {DATA_W{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_last_winner <= w_grant_owner;
            if (w_grant_owner == OWN_D) begin
              r_state     <= GNT_D;
              r_mem_read  <= d_read;
              r_mem_write <= d_write;
              r_mem_addr  <= d_addr;
              r_mem_wdata <= d_wdata;
            end else begin
              r_state     <= GNT_I;
              r_mem_read  <= 1'b1;
              r_mem_write <= 1'b0;
              r_mem_addr  <= i_addr;
              r_mem_wdata <= {DATA_W{1'b0}};
            end
          end
        end
        GNT_I, GNT_D: begin
          // A requester dropping early does not release the grant; only memory does.
          if (mem_ready) begin
            r_state     <= IDLE;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
        end
      endcase
    end
  end

  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  // Completion routing: ready and data reach only the current owner, same cycle.
  always_comb begin
    i_ready = 1'b0;
    d_ready = 1'b0;
    i_rdata = {DATA_W{1'b0}};
    d_rdata = {DATA_W{1'b0}};
    if (r_state == GNT_I) begin
      i_ready = mem_ready;
      i_rdata = mem_rdata;
    end else if (r_state == GNT_D) begin
      d_ready = mem_ready;
      d_rdata = mem_rdata;
    end else begin
      i_ready = 1'b0;
      d_ready = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; tie expectations follow MEM_ARB_RR_EN.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 28;
  localparam int DW = 128;

`ifdef MEM_ARB_RR_EN
  localparam logic TIE_FIRST = OWN_I;
`else
  localparam logic TIE_FIRST = OWN_D;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_read;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ready;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_read    (i_read),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_ready   (i_ready),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_grant(input string tag, input logic rd, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] wd);
    chk({tag, "_mem_read"},  mem_read,  rd);
    chk({tag, "_mem_write"}, mem_write, wr);
    chk({tag, "_mem_addr"},  mem_addr,  a);
    chk({tag, "_mem_wdata"}, mem_wdata, wd);
  endtask

  task automatic chk_all_zero(input string tag);
    chk_grant(tag, 1'b0, 1'b0, 28'h0, 128'h0);
    chk({tag, "_i_ready"}, i_ready, 1'b0);
    chk({tag, "_d_ready"}, d_ready, 1'b0);
    chk({tag, "_i_rdata"}, i_rdata, 128'h0);
    chk({tag, "_d_rdata"}, d_rdata, 128'h0);
  endtask

  // Memory completes now: only the owner sees ready/data, then strobes drop.
  task automatic complete(input string tag, input logic own, input logic [DW-1:0] data);
    mem_ready = 1'b1;
    mem_rdata = data;
    #1;
    chk({tag, "_i_ready"}, i_ready, (own == OWN_I));
    chk({tag, "_d_ready"}, d_ready, (own == OWN_D));
    chk({tag, "_i_rdata"}, i_rdata, (own == OWN_I) ? data : 128'h0);
    chk({tag, "_d_rdata"}, d_rdata, (own == OWN_D) ? data : 128'h0);
    tick();
    mem_ready = 1'b0;
    mem_rdata = 128'h0;
    #1;
    chk({tag, "_rd_clr"}, mem_read,  1'b0);
    chk({tag, "_wr_clr"}, mem_write, 1'b0);
    chk({tag, "_i_ready_clr"}, i_ready, 1'b0);
    chk({tag, "_d_ready_clr"}, d_ready, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    i_read    = 1'b0;
    d_read    = 1'b0;
    d_write   = 1'b0;
    i_addr    = 28'h0;
    d_addr    = 28'h0;
    d_wdata   = 128'h0;
    mem_ready = 1'b1;
    mem_rdata = {16{8'h3C}};
    #12;
    chk_all_zero("reset");
    mem_ready = 1'b0;
    mem_rdata = 128'h0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Lone I-cache read, memory answers three cycles after the grant.
    i_read = 1'b1;
    i_addr = 28'h0000010;
    tick();
    chk_grant("ird", 1'b1, 1'b0, 28'h0000010, 128'h0);
    chk("ird_no_iready", i_ready, 1'b0);
    tick();
    tick();
    chk_grant("ird_hold", 1'b1, 1'b0, 28'h0000010, 128'h0);
    complete("ird", OWN_I, {16{8'hA5}});
    i_read = 1'b0;
    tick();

    // Spurious mem_ready while idle must not reach either cache.
    mem_ready = 1'b1;
    mem_rdata = {16{8'h77}};
    #1;
    chk("spur_i_ready", i_ready, 1'b0);
    chk("spur_d_ready", d_ready, 1'b0);
    chk("spur_i_rdata", i_rdata, 128'h0);
    chk("spur_d_rdata", d_rdata, 128'h0);
    tick();
    chk("spur_mem_read", mem_read, 1'b0);
    mem_ready = 1'b0;
    mem_rdata = 128'h0;

    // D-cache write-back; inputs change after grant to prove the request is latched.
    d_write = 1'b1;
    d_addr  = 28'h0ABCDEF;
    d_wdata = 128'h123456789ABCDEF0_0FEDCBA987654321;
    tick();
    chk_grant("dwb", 1'b0, 1'b1, 28'h0ABCDEF, 128'h123456789ABCDEF0_0FEDCBA987654321);
    d_write = 1'b0;
    d_addr  = 28'h1111111;
    d_wdata = {16{8'hEE}};
    tick();
    chk_grant("dwb_hold", 1'b0, 1'b1, 28'h0ABCDEF, 128'h123456789ABCDEF0_0FEDCBA987654321);
    complete("dwb", OWN_D, {16{8'h5A}});
    d_wdata = 128'h0;

    // Tie: winner per policy, loser served after one idle cycle, then a second tie.
    i_read = 1'b1;
    i_addr = 28'h0000100;
    d_read = 1'b1;
    d_addr = 28'h0000200;
    tick();
    chk_grant("tie1", 1'b1, 1'b0, (TIE_FIRST == OWN_D) ? 28'h0000200 : 28'h0000100, 128'h0);
    complete("tie1", TIE_FIRST, {16{8'h11}});
    if (TIE_FIRST == OWN_D) d_read = 1'b0;
    else                    i_read = 1'b0;
    tick();
    chk_grant("tie2", 1'b1, 1'b0, (TIE_FIRST == OWN_D) ? 28'h0000100 : 28'h0000200, 128'h0);
    complete("tie2", ~TIE_FIRST, {16{8'h22}});
    i_read = 1'b0;
    d_read = 1'b0;
    tick();
    i_read = 1'b1;
    d_read = 1'b1;
    tick();
    chk_grant("tie3", 1'b1, 1'b0, (TIE_FIRST == OWN_D) ? 28'h0000200 : 28'h0000100, 128'h0);
    complete("tie3", TIE_FIRST, {16{8'h33}});
    i_read = 1'b0;
    d_read = 1'b0;
    tick();

    // Reset asserted during a D grant clears every output without a clock.
    d_read = 1'b1;
    d_addr = 28'h0BEEF00;
    tick();
    chk("rst_pre_grant", mem_read, 1'b1);
    mem_ready = 1'b1;
    mem_rdata = {16{8'h99}};
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    d_read    = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 128'h0;
    i_read    = 1'b1;
    i_addr    = 28'h0000300;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_grant("rst_after", 1'b1, 1'b0, 28'h0000300, 128'h0);
    complete("rst_after", OWN_I, {16{8'h44}});
    i_read = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single off-chip memory port between the instruction cache (miss refills fed to the IF stage's realigner) and the data cache (refills and write-backs). Each cache drives an unmodified cache-to-memory handshake. The arbiter grants one requester at a time, forwards the granted request to memory as registered outputs, and routes the returned data and ready back to the owner. It sits between the two cache instances and the top-level memory pins.

## Interface
Parameters:
- ADDR_W, 28, memory line-address width (128-bit lines)
- DATA_W, 128, line width

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset, asynchronous, active-low
- i_read  in  1  I-cache read request; held until i_ready
- i_addr  in  ADDR_W  I-cache line address
- i_rdata  out  DATA_W  line returned to I-cache
- i_ready  out  1  one-cycle completion pulse to I-cache
- d_read  in  1  D-cache read request
- d_write  in  1  D-cache write request; never asserted together with d_read
- d_addr  in  ADDR_W  D-cache line address
- d_wdata  in  DATA_W  D-cache write-back line
- d_rdata  out  DATA_W  line returned to D-cache
- d_ready  out  1  one-cycle completion pulse to D-cache
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_ready  in  1  memory completion pulse

## Operation
- FSM states: IDLE, GNT_I, GNT_D.
- IDLE:
  - Pending requests are i_req = i_read and d_req = d_read|d_write.
  - If none is pending, stay in IDLE.
  - If exactly one is pending, grant it.
  - If both are pending, resolve per Configuration.
- On a grant, at the clock edge: register mem_read/mem_write/mem_addr/mem_wdata from the winner and enter GNT_x.
  - An I-cache grant drives mem_write=0 and mem_wdata=0.
- GNT_x: memory outputs hold constant until mem_ready.
  - The owner's x_ready = mem_ready combinationally.
  - x_rdata = mem_rdata combinationally.
  - The non-owner's ready is 0.
- When mem_ready=1: clear mem_read/mem_write at the edge and return to IDLE.
- Each rdata output is 0 whenever its requester is not the owner.
- If a requester drops its request before ready (protocol violation), the grant is held anyway until mem_ready.
- mem_ready seen in IDLE is ignored; no ready is forwarded.
- A D-cache write-back followed by a refill consists of two separate requests, each arbitrated independently.

## Timing
- Reset (async assert):
  - State goes to IDLE.
  - mem_read, mem_write, mem_addr, mem_wdata, i_ready, d_ready, i_rdata, d_rdata are all 0.
  - The last-winner flag resets to "D".
- Reset mid-transaction abandons the transaction; nothing is replayed.
- Grant latency: request visible in IDLE at edge N → mem strobe high from cycle N+1.
- Ready latency: mem_ready in cycle M → x_ready in cycle M (zero added latency); strobe low from M+1.
- Minimum turnaround: one IDLE cycle between consecutive transactions.
  - The requester deasserts its request in the cycle after its ready pulse, so the IDLE cycle never re-grants a stale request.

## Configuration
- MEM_ARB_RR_EN defined: on simultaneous requests, round-robin.
  - The winner is the requester that did not win the previous grant.
  - The last-winner flag updates on every grant.
- MEM_ARB_RR_EN undefined: fixed priority, D-cache always wins ties.
  - The last-winner flag is not implemented.

## Structure
- Package mem_arb_pkg holds:
  - state enum (IDLE, GNT_I, GNT_D)
  - owner encoding constants OWN_I=0, OWN_D=1
- Sub-module mem_arb_pick: combinational winner select.
  - Inputs: i_req, d_req, last_winner.
  - Outputs: grant_valid, grant_owner.
  - The MEM_ARB_RR_EN conditional lives only inside this sub-module.
- The FSM and registered outputs live in mem_arbiter.

## Test plan
- Lone I-read:
  - Stimulus: i_read=1, i_addr=0x0000010; memory answers 3 cycles later with rdata=0xA5…A5.
  - Required: mem_read=1 and mem_addr=0x0000010 from the next cycle; i_ready pulses once with i_rdata=0xA5…A5; d_ready stays 0.
- D write-back:
  - Stimulus: d_write=1, d_addr=0x0ABCDEF, d_wdata=0x1234…
  - Required: mem_write=1 with matching addr/data held constant until mem_ready; d_ready pulses once; mem_read stays 0.
- Tie, fixed priority (macro undefined):
  - Stimulus: i_read and d_read rise in the same cycle.
  - Required: D is served first; I is granted after one IDLE cycle.
- Tie, round-robin (macro defined):
  - Stimulus: three back-to-back ties.
  - Required: winner sequence I, D, I (flag resets to D).
- Reset mid-transaction:
  - Stimulus: assert rst_n=0 while in GNT_D.
  - Required: all outputs are 0 immediately (asynchronously); after release, a pending i_read is granted normally.
- Spurious mem_ready in IDLE:
  - Required: no ready output pulses; state stays IDLE.
